mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory (1-cycle registered read, write on
//  clk edge) between NUM_REQ requesters using round-robin arbitration.
//  After reset, sweeps every address writing zero, then serves requests.
//  Sits between client engines and the memory array; owns all mem_* strobes.
// PARAMETERS
//  WIDTH    8    data word width, must match memory WIDTH
//  DEPTH    256  memory words; AW = $clog2(DEPTH) address bits
//  NUM_REQ  4    number of requesters, >= 2
// PORTS
//  clk              in   1              clock
//  reset            in   1              reset, synchronous, active-high
//  req_valid        in   NUM_REQ        per-requester request valid
//  req_write        in   NUM_REQ        1 = write, 0 = read
//  req_addr         in   NUM_REQ*AW     packed addresses, requester i at [i*AW +: AW]
//  req_wdata        in   NUM_REQ*WIDTH  packed write data, same packing
//  req_ready        out  NUM_REQ        grant; transfer when valid & ready
//  rsp_valid        out  NUM_REQ        read data for requester i on rsp_rdata
//  rsp_rdata        out  WIDTH          read data, shared by all requesters
//  init_done        out  1              1 once the clear sweep is complete
//  mem_write_enable out  1              to memory
//  mem_read_enable  out  1              to memory
//  mem_address      out  AW             to memory
//  mem_write_data   out  WIDTH          to memory
//  mem_read_data    in   WIDTH          from memory, valid 1 cycle after read issue
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, init_done=0, mem_write_enable=0,
//   mem_read_enable=0, pointer=0, sweep counter=0, state=INIT.
//  FSM INIT: each cycle drive mem_write_enable=1, mem_address=cnt,
//   mem_write_data=0; cnt++. At cnt==DEPTH-1 go to RUN. Takes DEPTH cycles.
//   req_ready=0 throughout.
//  FSM RUN: init_done=1. Combinational grant: first i with req_valid[i], searching
//   from pointer upward with wrap mod NUM_REQ. At most one req_ready bit set, and
//   only for a valid requester. Grant goes straight onto mem_* the same cycle:
//   write uses mem_write_enable; read uses mem_read_enable.
//  Pointer update: on a handshake with requester g, pointer <= (g+1) mod NUM_REQ.
//   No handshake leaves the pointer unchanged. Starvation-free; every valid
//   requester is granted within NUM_REQ cycles.
//  Read response: register the read grant index. Exactly one cycle after the
//   read handshake, rsp_valid[g]=1 for 1 cycle and rsp_rdata=mem_read_data.
//   Writes produce no response.
//  Back-to-back: one transfer per cycle, including read→write and write→read.
//  Same-address read after a write in the previous cycle returns the new data.
//  Requesters hold valid and payload until ready; the arbiter does not buffer.
//  Idle RUN: all mem strobes 0; mem_address/wdata don't-care, drive 0.
//  Reset mid-INIT restarts the sweep at address 0. Reset with a read in flight
//   gives no rsp_valid. rsp_valid is cleared on the reset cycle.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum logic {ST_INIT, ST_RUN} arb_state_t;
//   localparam helpers for AW and requester index width ($clog2(NUM_REQ)).
//  Sub-module rr_arbiter #(N): req vector and pointer in, one-hot grant and
//   grant index out; purely combinational. Pointer register lives in the parent.
// TESTING
//  1 Reset, then idle: mem_write_enable=1 for exactly 256 cycles, addr 0..255,
//    data 0; init_done rises the next cycle; then read addr 0x10 gives rsp 0x00.
//  2 Requester 1 writes 0xA5 to 0x10, then reads 0x10: rsp_valid[1] one cycle
//    after the read handshake, rsp_rdata=0xA5; no other rsp_valid bit set.
//  3 All 4 requesters valid continuously, pointer=0: grants in order
//    0,1,2,3,0,...; each requester receives exactly 1 grant per 4 cycles.
//  4 Only requesters 2 and 0 valid, pointer=3: grant 0 first, then 2, then 0
//    (wrap-around).
//  5 Assert reset at sweep address 100: sweep restarts at 0 and completes
//    256 writes.
//  6 Read to 0x20 issued, reset the next cycle: no rsp_valid;
//    req_ready=0 until init_done.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {ST_INIT, ST_RUN} arb_state_t;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_DEPTH   = 256;
    localparam int unsigned DEF_NUM_REQ = 4;

    // Address bits for a memory of the given depth (at least 1).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to hold a requester index (at least 1).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping to the lowest asserted request below it.
import mem_arb_pkg::*;

module rr_arbiter #(
    parameter  int unsigned N  = DEF_NUM_REQ,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_any_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= 32'(ptr_i))) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        grant_any_o = found;
        grant_idx_o = idx;
        grant_o     = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-port synchronous memory between requesters,
// with a zero-fill sweep of the whole array after reset.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter  int unsigned WIDTH   = DEF_WIDTH,
    parameter  int unsigned DEPTH   = DEF_DEPTH,
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned AW      = addr_width(DEPTH),
    localparam int unsigned IW      = idx_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ*AW-1:0]    req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     init_done,
    output logic                     mem_write_enable,
    output logic                     mem_read_enable,
    output logic [AW-1:0]            mem_address,
    output logic [WIDTH-1:0]         mem_write_data,
    input  logic [WIDTH-1:0]         mem_read_data
);

    arb_state_t         state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;
    logic               sel_write;
    logic [AW-1:0]      sel_addr;
    logic [WIDTH-1:0]   sel_wdata;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    // Payload of the granted requester.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state and memory strobes; everything is held quiet while reset is high.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        ptr_d            = ptr_q;
        rsp_valid_d      = '0;
        req_ready        = '0;
        init_done        = 1'b0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        if (!reset) begin
            case (state_q)
                ST_INIT: begin
                    mem_write_enable = 1'b1;
                    mem_address      = cnt_q;
                    cnt_d            = cnt_q + AW'(1);
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    if (grant_any) begin
                        req_ready   = grant_oh;
                        mem_address = sel_addr;
                        if (sel_write) begin
                            mem_write_enable = 1'b1;
                            mem_write_data   = sel_wdata;
                        end else begin
                            mem_read_enable = 1'b1;
                            rsp_valid_d     = grant_oh;
                        end
                        ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Memory output register already aligns read data with the response cycle.
    assign rsp_valid = reset ? '0 : rsp_valid_q;
    assign rsp_rdata = mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;

    localparam int W = 8;
    localparam int D = 256;
    localparam int N = 4;
    localparam int A = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [N*A-1:0] req_addr;
    logic [N*W-1:0] req_wdata;
    logic [W-1:0]   rsp_rdata, mem_wd, mem_rd;
    logic           init_done, mem_we, mem_re;
    logic [A-1:0]   mem_a;

    logic [W-1:0] mem [D];

    typedef struct {int idx; logic [7:0] d;} rsp_t;
    logic [3:0] gq[$];
    rsp_t       rq[$];
    logic [3:0] eg;
    rsp_t       er;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.WIDTH(W), .DEPTH(D), .NUM_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .mem_write_enable(mem_we), .mem_read_enable(mem_re), .mem_address(mem_a),
        .mem_write_data(mem_wd), .mem_read_data(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
        if (mem_re) mem_rd <= mem[mem_a];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: every grant and every response is matched against the queues.
    always @(negedge clk) begin
        if (req_ready != 0) begin
            if (gq.size() == 0) chk("unexp_gnt", 32'(req_ready), 0);
            else begin
                eg = gq.pop_front();
                chk("gnt", 32'(req_ready), 32'(eg));
            end
        end
        if (rsp_valid != 0) begin
            if (rq.size() == 0) chk("unexp_rsp", 32'(rsp_valid), 0);
            else begin
                er = rq.pop_front();
                chk("rsp_vec", 32'(rsp_valid), 32'(1) << er.idx);
                chk("rsp_data", 32'(rsp_rdata), 32'(er.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expect a full zero sweep starting at the next negedge, then init_done.
    task automatic sweep_check(input string nm);
        int c, wcount, errs;
        wcount = 0; errs = 0;
        for (c = 0; c < 300; c++) begin
            @(negedge clk);
            if (init_done) break;
            if (req_ready != 0) errs++;
            if (mem_we && !mem_re && mem_wd == 0) begin
                if (mem_a != A'(wcount)) errs++;
                wcount++;
            end else errs++;
        end
        chk({nm, "_writes"}, 32'(wcount), 256);
        chk({nm, "_len"}, 32'(c), 256);
        chk({nm, "_errs"}, 32'(errs), 0);
        @(posedge clk); #1;
    endtask

    task automatic xfer(input int r, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
        bit got;
        gq.push_back(4'(1 << r));
        if (!wr) rq.push_back('{r, exp_rd});
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*A +: A]  = a;
        req_wdata[r*W +: W] = d;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = req_ready[r];
        end
        if (!got) chk("xfer_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    initial begin
        int gcnt [N];
        bit found;
        reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        tick(); tick();
        @(negedge clk);
        chk("reset_outs", {req_ready, rsp_valid, 29'(init_done), mem_we, mem_re},
            {4'b0, 4'b0, 29'b0, 1'b0, 1'b0});
        tick();
        reset = 1'b0;

        // Test 1: sweep, then read of a cleared word
        sweep_check("sweep1");
        xfer(0, 1'b0, 8'h10, 8'h00, 8'h00);

        // Test 2: write then immediate read of the same address
        xfer(1, 1'b1, 8'h10, 8'hA5, 8'h00);
        xfer(1, 1'b0, 8'h10, 8'h00, 8'hA5);
        tick();
        @(negedge clk);
        chk("idle_strobes", {22'b0, mem_we, mem_re, mem_a}, 0);
        tick();

        // Test 3: all requesters, pointer back to 0 first
        xfer(3, 1'b1, 8'h50, 8'h77, 8'h00);
        for (int r = 0; r < 2; r++) begin
            gq.push_back(4'b0001); gq.push_back(4'b0010);
            gq.push_back(4'b0100); gq.push_back(4'b1000);
            rq.push_back('{1, 8'h11}); rq.push_back('{3, 8'h22});
        end
        req_write = 4'b0101;
        req_addr  = {8'h31, 8'h31, 8'h30, 8'h30};
        req_wdata = {8'h00, 8'h22, 8'h00, 8'h11};
        req_valid = 4'b1111;
        foreach (gcnt[i]) gcnt[i] = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (req_ready[i]) gcnt[i]++;
            tick();
        end
        req_valid = '0;
        for (int i = 0; i < N; i++) chk($sformatf("fair%0d", i), 32'(gcnt[i]), 2);

        // Test 4: pointer to 3, then requesters 0 and 2 with wrap
        xfer(2, 1'b1, 8'h40, 8'h5A, 8'h00);
        gq.push_back(4'b0001); gq.push_back(4'b0100); gq.push_back(4'b0001);
        rq.push_back('{0, 8'hA5}); rq.push_back('{2, 8'h22}); rq.push_back('{0, 8'hA5});
        req_write = '0;
        req_addr  = {8'h00, 8'h31, 8'h00, 8'h10};
        req_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick();
        end
        req_valid = '0;
        tick(); tick();

        // Test 5: reset in the middle of a sweep
        reset = 1'b1; tick(); reset = 1'b0;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            found = mem_we && (mem_a == 8'd100);
        end
        chk("t5_reach100", 32'(found), 1);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        sweep_check("sweep2");
        xfer(1, 1'b0, 8'h10, 8'h00, 8'h00);

        // Test 6: reset right after a read handshake
        gq.push_back(4'b0001);
        req_write[0] = 1'b0; req_addr[7:0] = 8'h20; req_valid[0] = 1'b1;
        @(negedge clk);
        chk("t6_gnt", 32'(req_ready[0]), 1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_no_rsp", 32'(rsp_valid), 0);
        chk("t6_no_rdy", 32'(req_ready), 0);
        tick(); tick();
        reset = 1'b0;
        gq.push_back(4'b0001);
        rq.push_back('{0, 8'h00});
        sweep_check("sweep3");
        req_valid = '0;
        tick(); tick(); tick();

        chk("gq_empty", 32'(gq.size()), 0);
        chk("rq_empty", 32'(rq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
